// File: rtl/synchronous_fifo_pkg.sv
// synchronous_fifo_pkg: default geometry, thresholds and pointer/count types for synchronous_fifo_thresh
package synchronous_fifo_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_AF_LEVEL = 2**DEF_ADDR_WIDTH - 4;
  localparam int DEF_AE_LEVEL = 4;
  typedef logic [DEF_ADDR_WIDTH:0] ptr_t;
  typedef logic [DEF_ADDR_WIDTH:0] count_t;
endpackage

// File: rtl/fifo_mem_2p.sv
// fifo_mem_2p: FIFO storage, one sync write port and one read port (registered, or combinational under FIFO_FWFT_EN)
module fifo_mem_2p import synchronous_fifo_pkg::*; #(
  parameter int DW = DEF_DATA_WIDTH,
  parameter int AW = DEF_ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
`ifdef FIFO_FWFT_EN
  logic unused_rst;
  assign unused_rst = rst;
  assign rdata = re ? mem[raddr] : '0;
`else
  logic [DW-1:0] rdata_d, rdata_q;
  always_comb rdata_d = re ? mem[raddr] : rdata_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata_q <= '0;
    else rdata_q <= rdata_d;
  end
  assign rdata = rdata_q;
`endif
endmodule

// File: rtl/synchronous_fifo_thresh.sv
// synchronous_fifo_thresh: single-clock FIFO with count, almost flags and sticky errors
// FIFO_FWFT_EN selects first-word-fall-through reads; default is registered reads.
module synchronous_fifo_thresh import synchronous_fifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_LEVEL = 2**ADDR_WIDTH - 4,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  FIFO_full,
  output logic                  FIFO_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AF = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE = (ADDR_WIDTH+1)'(AE_LEVEL);
  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic full_q, full_d, empty_q, empty_d, af_q, af_d, ae_q, ae_d;
  logic ovf_q, ovf_d, udf_q, udf_d, wr_acc, rd_acc, mem_re;
  always_comb begin
    rd_acc = rd_en & ~empty_q;
    wr_acc = wr_en & (~full_q | rd_acc);
    wr_ptr_d = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, wr_acc};
    rd_ptr_d = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, rd_acc};
    count_d = count_q + {{ADDR_WIDTH{1'b0}}, wr_acc} - {{ADDR_WIDTH{1'b0}}, rd_acc};
    full_d = count_d == DEPTH;
    empty_d = count_d == '0;
    af_d = count_d >= AF;
    ae_d = count_d <= AE;
    ovf_d = (wr_en & ~wr_acc) | (ovf_q & ~clr_err);
    udf_d = (rd_en & ~rd_acc) | (udf_q & ~clr_err);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
      af_q <= 1'b0;
      ae_q <= 1'b1;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      full_q <= full_d;
      empty_q <= empty_d;
      af_q <= af_d;
      ae_q <= ae_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end
`ifdef FIFO_FWFT_EN
  assign mem_re = ~empty_q;
  assign rd_valid = ~empty_q;
`else
  logic rd_valid_q;
  assign mem_re = rd_acc;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_valid_q <= 1'b0;
    else rd_valid_q <= rd_acc;
  end
  assign rd_valid = rd_valid_q;
`endif
  fifo_mem_2p #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_mem (
    .clk(clk),
    .rst(rst),
    .we(wr_acc),
    .waddr(wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata(data_in),
    .re(mem_re),
    .raddr(rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata(data_out)
  );
  assign FIFO_full = full_q;
  assign FIFO_empty = empty_q;
  assign almost_full = af_q;
  assign almost_empty = ae_q;
  assign count = count_q;
  assign overflow = ovf_q;
  assign underflow = udf_q;
endmodule

// File: tb/tb_synchronous_fifo_thresh.sv
// tb_synchronous_fifo_thresh: directed checks of fill, drain, boundaries, wrap and async reset
module tb_synchronous_fifo_thresh;
  logic clk, rst, wr_en, rd_en, clr_err;
  logic [7:0] data_in, data_out;
  logic rd_valid, full, empty, af, ae, ovf, udf;
  logic [5:0] count;
  int errors = 0;
  int checks = 0;

  synchronous_fifo_thresh dut (
    .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .clr_err(clr_err), .data_out(data_out), .rd_valid(rd_valid),
    .FIFO_full(full), .FIFO_empty(empty), .almost_full(af), .almost_empty(ae),
    .count(count), .overflow(ovf), .underflow(udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; wr_en = 0; rd_en = 0; clr_err = 0; data_in = 0;
    #7;
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if ({full, empty, af, ae} !== 4'b0101) begin errors++; $display("FAIL reset_flags got %b want 0101", {full, empty, af, ae}); end
    checks++; if ({data_out, rd_valid, ovf, udf} !== 11'd0) begin errors++; $display("FAIL reset_out got %h/%b%b%b want 0", data_out, rd_valid, ovf, udf); end
    rst = 1'b1;
    tick;
  endtask

  task automatic test_fill;
    for (int i = 0; i < 32; i++) begin
      data_in = 8'(i); wr_en = 1;
      tick;
      if (i == 26) begin checks++; if (af !== 1'b0) begin errors++; $display("FAIL fill_af27 got %b want 0", af); end end
      if (i == 27) begin checks++; if (af !== 1'b1) begin errors++; $display("FAIL fill_af28 got %b want 1", af); end end
      if (i == 30) begin checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_full31 got %b want 0", full); end end
    end
    checks++; if ({full, count} !== {1'b1, 6'd32}) begin errors++; $display("FAIL fill_full got %b/%0d want 1/32", full, count); end
    data_in = 8'hFF;
    tick;
    wr_en = 0;
    checks++; if ({ovf, count} !== {1'b1, 6'd32}) begin errors++; $display("FAIL fill_overflow got %b/%0d want 1/32", ovf, count); end
    checks++; if (dut.u_mem.mem[0] !== 8'h00) begin errors++; $display("FAIL fill_mem0 got %h want 00", dut.u_mem.mem[0]); end
    checks++; if (dut.u_mem.mem[31] !== 8'h1F) begin errors++; $display("FAIL fill_mem31 got %h want 1f", dut.u_mem.mem[31]); end
  endtask

  task automatic test_drain;
    for (int i = 0; i < 32; i++) begin
      rd_en = 1;
      tick;
      checks++; if ({rd_valid, data_out} !== {1'b1, 8'(i)}) begin errors++; $display("FAIL drain_rd%0d got %b/%h want 1/%h", i, rd_valid, data_out, 8'(i)); end
      rd_en = 0;
      tick;
      checks++; if ({rd_valid, data_out} !== {1'b0, 8'(i)}) begin errors++; $display("FAIL drain_hold%0d got %b/%h want 0/%h", i, rd_valid, data_out, 8'(i)); end
    end
    checks++; if ({empty, ae, count} !== {2'b11, 6'd0}) begin errors++; $display("FAIL drain_empty got %b%b/%0d want 11/0", empty, ae, count); end
    rd_en = 1;
    tick;
    rd_en = 0;
    checks++; if ({udf, rd_valid, data_out} !== {2'b10, 8'h1F}) begin errors++; $display("FAIL drain_underflow got %b%b/%h want 10/1f", udf, rd_valid, data_out); end
    clr_err = 1;
    tick;
    clr_err = 0;
    checks++; if ({ovf, udf} !== 2'b00) begin errors++; $display("FAIL drain_clr got %b%b want 00", ovf, udf); end
  endtask

  task automatic test_boundaries;
    for (int i = 0; i < 32; i++) begin
      data_in = 8'(8'h40 + i); wr_en = 1;
      tick;
    end
    data_in = 8'hAA; rd_en = 1;
    tick;
    checks++; if ({data_out, count, full, ovf} !== {8'h40, 6'd32, 2'b10}) begin errors++; $display("FAIL bnd_full got %h/%0d/%b%b want 40/32/10", data_out, count, full, ovf); end
    wr_en = 0;
    for (int i = 0; i < 32; i++) tick;
    rd_en = 0;
    checks++; if ({data_out, empty} !== {8'hAA, 1'b1}) begin errors++; $display("FAIL bnd_last got %h/%b want aa/1", data_out, empty); end
    data_in = 8'h55; wr_en = 1; rd_en = 1;
    tick;
    wr_en = 0; rd_en = 0;
    checks++; if ({udf, count, empty} !== {1'b1, 6'd1, 1'b0}) begin errors++; $display("FAIL bnd_empty got %b/%0d/%b want 1/1/0", udf, count, empty); end
    rd_en = 1;
    tick;
    rd_en = 0;
    checks++; if ({data_out, rd_valid, count} !== {8'h55, 1'b1, 6'd0}) begin errors++; $display("FAIL bnd_read got %h/%b/%0d want 55/1/0", data_out, rd_valid, count); end
    clr_err = 1;
    tick;
    clr_err = 0;
  endtask

  task automatic test_wrap;
    logic [7:0] d;
    int bad = 0;
    for (int i = 0; i < 96; i++) begin
      d = 8'($urandom);
      data_in = d; wr_en = 1;
      tick;
      wr_en = 0;
      if (count !== 6'd1) bad++;
      rd_en = 1;
      tick;
      rd_en = 0;
      if (data_out !== d || count !== 6'd0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL wrap got %0d bad iterations want 0", bad); end
    checks++; if ({ovf, udf, empty} !== 3'b001) begin errors++; $display("FAIL wrap_flags got %b want 001", {ovf, udf, empty}); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 33; i++) begin
      data_in = 8'(i); wr_en = 1;
      tick;
    end
    wr_en = 0; rd_en = 1;
    for (int i = 0; i < 22; i++) tick;
    rd_en = 0;
    checks++; if ({count, ovf} !== {6'd10, 1'b1}) begin errors++; $display("FAIL mid_pre got %0d/%b want 10/1", count, ovf); end
    #3 rst = 1'b0;
    #1;
    checks++; if ({count, empty, ae, full, ovf} !== {6'd0, 4'b1100}) begin errors++; $display("FAIL mid_reset got %0d/%b%b%b%b want 0/1100", count, empty, ae, full, ovf); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL mid_dout got %h want 00", data_out); end
    #2 rst = 1'b1;
    tick;
  endtask

  task automatic test_fwft;
    data_in = 8'h5A; wr_en = 1;
    tick;
    wr_en = 0;
    checks++; if ({data_out, rd_valid, empty} !== {8'h5A, 2'b10}) begin errors++; $display("FAIL fwft_head got %h/%b%b want 5a/10", data_out, rd_valid, empty); end
    rd_en = 1;
    tick;
    rd_en = 0;
    checks++; if ({data_out, rd_valid, empty} !== {8'h00, 2'b01}) begin errors++; $display("FAIL fwft_pop got %h/%b%b want 00/01", data_out, rd_valid, empty); end
  endtask

  initial begin
    test_reset;
    test_fill;
`ifdef FIFO_FWFT_EN
    test_reset_mid;
    test_fwft;
`else
    test_drain;
    test_boundaries;
    test_wrap;
    test_reset_mid;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
